// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone slave with two compare timers and a free-running cycle counter
module wb_timer #(
  parameter bit          cycle_cnt_en  = 1'b1,
  parameter logic [31:0] reset_compare = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        intr
);

  // Only the word index is decoded; the remaining address bits are don't-care.
  logic        unused_adr;
  logic        access;
  logic        wr;
  logic        rd;
  logic [2:0]  idx;
  logic [31:0] lane_mask;
  logic [31:0] rd_data;
  logic [31:0] cycle_q;

  logic [1:0]  en_q;
  logic [1:0]  ar_q;
  logic [1:0]  irqen_q;
  logic [1:0]  trig_q;
  logic [31:0] cmp_q [2];
  logic [31:0] cnt_q [2];

  logic [1:0]  wr_tcr;
  logic [1:0]  wr_cmp;
  logic [1:0]  wr_cnt;
  logic [1:0]  match;

  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // An access is accepted only while no ack is outstanding, so every
  // transfer takes two cycles and back-to-back strobes ack every other cycle.
  assign access    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr        = access & wb_we_i;
  assign rd        = access & ~wb_we_i;
  assign idx       = wb_adr_i[4:2];
  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  // Per-timer register write strobes and match detection; a counter write
  // suppresses match evaluation for that timer in the same cycle.
  always_comb begin
    wr_tcr = '0;
    wr_cmp = '0;
    wr_cnt = '0;
    match  = '0;
    for (int t = 0; t < 2; t++) begin
      wr_tcr[t] = wr && (idx == 3'(3 * t)) && wb_sel_i[0];
      wr_cmp[t] = wr && (idx == 3'(3 * t + 1));
      wr_cnt[t] = wr && (idx == 3'(3 * t + 2));
      match[t]  = en_q[t] && (cnt_q[t] == cmp_q[t]) && !wr_cnt[t];
    end
  end

  // Timer state: counter, compare and control bits for both timers.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < 2; t++) begin
      if (rst_i) begin
        cnt_q[t]   <= '0;
        cmp_q[t]   <= reset_compare;
        en_q[t]    <= 1'b0;
        ar_q[t]    <= 1'b0;
        irqen_q[t] <= 1'b0;
        trig_q[t]  <= 1'b0;
      end else begin
        // Counter: bus load, then match (reload or hold), then count.
        if (wr_cnt[t]) begin
          cnt_q[t] <= (cnt_q[t] & ~lane_mask) | (wb_dat_i & lane_mask);
        end else if (match[t]) begin
          if (ar_q[t]) begin
            cnt_q[t] <= '0;
          end
        end else if (en_q[t]) begin
          cnt_q[t] <= cnt_q[t] + 32'd1;
        end

        // The match above already used the old compare value.
        if (wr_cmp[t]) begin
          cmp_q[t] <= (cmp_q[t] & ~lane_mask) | (wb_dat_i & lane_mask);
        end

        // A written EN always wins over the one-shot auto-clear.
        if (wr_tcr[t]) begin
          en_q[t]    <= wb_dat_i[0];
          ar_q[t]    <= wb_dat_i[1];
          irqen_q[t] <= wb_dat_i[2];
        end else if (match[t] && !ar_q[t]) begin
          en_q[t] <= 1'b0;
        end

        // Setting on a match beats a simultaneous write-1-to-clear.
        if (match[t]) begin
          trig_q[t] <= 1'b1;
        end else if (wr_tcr[t] && wb_dat_i[3]) begin
          trig_q[t] <= 1'b0;
        end
      end
    end
  end

  generate
    if (cycle_cnt_en) begin : g_cycle
      // Free-running cycle counter, wraps silently.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cycle_q <= '0;
        end else begin
          cycle_q <= cycle_q + 32'd1;
        end
      end
    end else begin : g_no_cycle
      assign cycle_q = '0;
    end
  endgenerate

  // Read data selection by word index.
  always_comb begin
    rd_data = '0;
    case (idx)
      3'd0:    rd_data = {28'd0, trig_q[0], irqen_q[0], ar_q[0], en_q[0]};
      3'd1:    rd_data = cmp_q[0];
      3'd2:    rd_data = cnt_q[0];
      3'd3:    rd_data = {28'd0, trig_q[1], irqen_q[1], ar_q[1], en_q[1]};
      3'd4:    rd_data = cmp_q[1];
      3'd5:    rd_data = cnt_q[1];
      3'd6:    rd_data = cycle_q;
      default: rd_data = '0;
    endcase
  end

  // Registered bus response and interrupt; reset drops any pending ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      intr     <= 1'b0;
    end else begin
      wb_ack_o <= access;
      if (rd) begin
        wb_dat_o <= rd_data;
      end
      intr <= |(trig_q & irqen_q);
    end
  end

endmodule
